// File: rtl/keypad_key_injector_pkg.sv
// Shared keypad constants: active-low column codes, FSM encodings and the digit-to-row/column map.
// The 7-seg multiplexer reuses the scan-wrap constants.
package keypad_key_injector_pkg;

    localparam logic [2:0] COL0     = 3'b011;
    localparam logic [2:0] COL1     = 3'b101;
    localparam logic [2:0] COL2     = 3'b110;
    localparam logic [2:0] COL_IDLE = 3'b111;
    localparam logic [2:0] SEL_LAST = 3'd5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
    localparam logic [1:0] ST_PRESS = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    typedef struct packed {
        logic       legal;
        logic [1:0] row;
        logic [2:0] col;
    } key_map_t;

    // Physical 3x4 layout: 1-2-3 / 4-5-6 / 7-8-9 / *-0-#
    function automatic key_map_t map_key(input logic [3:0] code);
        key_map_t m;
        m.legal = 1'b1;
        m.row   = 2'd0;
        m.col   = COL_IDLE;
        case (code)
            4'd0: begin m.row = 2'd3; m.col = COL1; end
            4'd1: begin m.row = 2'd0; m.col = COL0; end
            4'd2: begin m.row = 2'd0; m.col = COL1; end
            4'd3: begin m.row = 2'd0; m.col = COL2; end
            4'd4: begin m.row = 2'd1; m.col = COL0; end
            4'd5: begin m.row = 2'd1; m.col = COL1; end
            4'd6: begin m.row = 2'd1; m.col = COL2; end
            4'd7: begin m.row = 2'd2; m.col = COL0; end
            4'd8: begin m.row = 2'd2; m.col = COL1; end
            4'd9: begin m.row = 2'd2; m.col = COL2; end
            default: m.legal = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/keypad_key_injector_scan_boundary_det.sv
// Flags the cycle where the row scanner wraps from 5 back to 0.
// Out-of-range sel values never produce a boundary.
module keypad_key_injector_scan_boundary_det
    import keypad_key_injector_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] sel,
    output logic       boundary
);

    logic [2:0] sel_q_reg;

    // Reset value 0 guarantees no spurious wrap on the first cycle out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q_reg <= 3'd0;
        end else begin
            sel_q_reg <= sel;
        end
    end

    assign boundary = (sel_q_reg == SEL_LAST) && (sel == 3'd0);

endmodule

// File: rtl/keypad_key_injector.sv
// Plays a 3x4 keypad against the row scanner: accepts one key code, arms on a scan wrap,
// holds the key's column for HOLD_SCANS scans, then releases for GAP_SCANS scans.
module keypad_key_injector
    import keypad_key_injector_pkg::*;
#(
    parameter int unsigned HOLD_SCANS = 8,
    parameter int unsigned GAP_SCANS  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] sel,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    output logic [2:0] column,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_SCANS - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_SCANS - 1);

    logic [1:0] state_reg;
    logic [1:0] row_reg;
    logic [2:0] col_reg;
    logic [7:0] hold_cnt_reg;
    logic [7:0] gap_cnt_reg;
    logic       done_reg;
    logic       err_reg;
    logic       boundary;
    logic       transfer;
    key_map_t   key_map;

    keypad_key_injector_scan_boundary_det u_boundary (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel      (sel),
        .boundary (boundary)
    );

    assign key_map  = map_key(key_code);
    assign transfer = key_valid && key_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            row_reg      <= 2'd0;
            col_reg      <= COL_IDLE;
            hold_cnt_reg <= 8'd0;
            gap_cnt_reg  <= 8'd0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (transfer) begin
                        if (key_map.legal) begin
                            row_reg   <= key_map.row;
                            col_reg   <= key_map.col;
                            state_reg <= ST_ARM;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                // Wait for a wrap so the key is held for whole scans only.
                ST_ARM: begin
                    if (boundary) begin
                        state_reg    <= ST_PRESS;
                        hold_cnt_reg <= 8'd0;
                    end
                end
                ST_PRESS: begin
                    if (boundary) begin
                        if (hold_cnt_reg == HOLD_LAST) begin
                            state_reg   <= ST_GAP;
                            gap_cnt_reg <= 8'd0;
                        end else begin
                            hold_cnt_reg <= hold_cnt_reg + 8'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (boundary) begin
                        if (gap_cnt_reg == GAP_LAST) begin
                            done_reg  <= 1'b1;
                            state_reg <= ST_IDLE;
                        end else begin
                            gap_cnt_reg <= gap_cnt_reg + 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    // Column follows sel combinationally, matching the combinational key decoder downstream.
    always_comb begin
        column = COL_IDLE;
        if ((state_reg == ST_PRESS) && (sel == {1'b0, row_reg})) begin
            column = col_reg;
        end
    end

    assign key_ready = (state_reg == ST_IDLE);
    assign busy      = (state_reg != ST_IDLE);
    assign done      = done_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_keypad_key_injector.sv
// Directed bench: free-running count6 scanner, two injector instances (8/4 and 1/1 scans).
module tb_keypad_key_injector;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] sel = 3'd0;

    logic       a_key_valid = 1'b0;
    logic [3:0] a_key_code = 4'd0;
    logic       a_key_ready, a_busy, a_done, a_err;
    logic [2:0] a_column;

    logic       b_key_valid = 1'b0;
    logic [3:0] b_key_code = 4'd0;
    logic       b_key_ready, b_busy, b_done, b_err;
    logic [2:0] b_column;

    int n_cmp = 0;
    int n_fail = 0;

    int ob_n_act, ob_n011, ob_n101, ob_n110, ob_wrong_sel, ob_first_act, ob_last_act;
    int ob_n_done, ob_first_done, ob_n_err, ob_first_err, ob_n_xfer, ob_xfer_idx;
    int ob_ready_busy, ob_n_busy, ob_n_notready;
    logic [2:0] ob_first_col;

    keypad_key_injector #(.HOLD_SCANS(8), .GAP_SCANS(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .sel(sel), .key_valid(a_key_valid), .key_code(a_key_code),
        .key_ready(a_key_ready), .column(a_column), .busy(a_busy), .done(a_done), .err(a_err)
    );

    keypad_key_injector #(.HOLD_SCANS(1), .GAP_SCANS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .sel(sel), .key_valid(b_key_valid), .key_code(b_key_code),
        .key_ready(b_key_ready), .column(b_column), .busy(b_busy), .done(b_done), .err(b_err)
    );

    always #5 clk = ~clk;

    // Row scanner model: advances just after every rising edge.
    always @(posedge clk) begin
        #1;
        sel = (sel == 3'd5) ? 3'd0 : sel + 3'd1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=finish", $time);
        $fatal(1);
    end

    task automatic offer(input bit use_b, input logic [3:0] code);
        @(negedge clk);
        if (use_b) begin b_key_valid = 1'b1; b_key_code = code; end
        else begin a_key_valid = 1'b1; a_key_code = code; end
        @(posedge clk);
        #1;
        if (use_b) b_key_valid = 1'b0; else a_key_valid = 1'b0;
    endtask

    // Collects per-cycle observations; index 0 is the first cycle after the call.
    task automatic observe(input bit use_b, input int cycles, input logic [2:0] exp_sel);
        bit drop;
        logic [2:0] c;
        logic rdy, bsy, dn, er, vld;
        ob_n_act = 0; ob_n011 = 0; ob_n101 = 0; ob_n110 = 0; ob_wrong_sel = 0;
        ob_first_act = -1; ob_last_act = -1; ob_n_done = 0; ob_first_done = -1;
        ob_n_err = 0; ob_first_err = -1; ob_n_xfer = 0; ob_xfer_idx = -1;
        ob_ready_busy = 0; ob_n_busy = 0; ob_n_notready = 0; ob_first_col = 3'b111;
        drop = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (drop) begin
                if (use_b) b_key_valid = 1'b0; else a_key_valid = 1'b0;
                drop = 1'b0;
            end
            c   = use_b ? b_column    : a_column;
            rdy = use_b ? b_key_ready : a_key_ready;
            bsy = use_b ? b_busy      : a_busy;
            dn  = use_b ? b_done      : a_done;
            er  = use_b ? b_err       : a_err;
            vld = use_b ? b_key_valid : a_key_valid;
            if (c !== 3'b111) begin
                ob_n_act++;
                if (ob_first_act < 0) begin ob_first_act = i; ob_first_col = c; end
                ob_last_act = i;
                if (c === 3'b011) ob_n011++;
                if (c === 3'b101) ob_n101++;
                if (c === 3'b110) ob_n110++;
                if (sel !== exp_sel) ob_wrong_sel++;
            end
            if (dn === 1'b1) begin ob_n_done++; if (ob_first_done < 0) ob_first_done = i; end
            if (er === 1'b1) begin ob_n_err++; if (ob_first_err < 0) ob_first_err = i; end
            if (bsy === 1'b1) ob_n_busy++;
            if (rdy !== 1'b1) ob_n_notready++;
            if (rdy === 1'b1 && bsy === 1'b1) ob_ready_busy++;
            if (vld === 1'b1 && rdy === 1'b1) begin ob_n_xfer++; ob_xfer_idx = i; drop = 1'b1; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (a_column !== 3'b111) begin n_fail++; $display("FAIL reset_column got=%b exp=111", a_column); end
        n_cmp++; if (a_key_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", a_key_ready); end
        n_cmp++; if ({a_busy, a_done, a_err} !== 3'b000) begin n_fail++; $display("FAIL reset_busy_done_err got=%b exp=000", {a_busy, a_done, a_err}); end
        n_cmp++; if ({b_key_ready, b_column, b_busy} !== 5'b1_111_0) begin n_fail++; $display("FAIL reset_b got=%b exp=11110", {b_key_ready, b_column, b_busy}); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_key2();
        offer(1'b0, 4'd2);
        observe(1'b0, 100, 3'd0);
        n_cmp++; if (ob_n101 !== 8 || ob_n_act !== 8) begin n_fail++; $display("FAIL key2_active got101=%0d gotall=%0d exp=8", ob_n101, ob_n_act); end
        n_cmp++; if (ob_wrong_sel !== 0) begin n_fail++; $display("FAIL key2_row got_wrong_sel=%0d exp=0", ob_wrong_sel); end
        n_cmp++; if (ob_first_act < 0 || ob_first_act > 11) begin n_fail++; $display("FAIL key2_latency got=%0d exp<=11", ob_first_act); end
        n_cmp++; if (ob_last_act - ob_first_act !== 42) begin n_fail++; $display("FAIL key2_span got=%0d exp=42", ob_last_act - ob_first_act); end
        n_cmp++; if (ob_n_done !== 1 || ob_first_done - ob_last_act !== 25) begin n_fail++; $display("FAIL key2_done count=%0d offset=%0d exp=1/25", ob_n_done, ob_first_done - ob_last_act); end
        n_cmp++; if (ob_n_busy !== ob_first_done || ob_n_err !== 0) begin n_fail++; $display("FAIL key2_busy busy=%0d err=%0d exp=%0d/0", ob_n_busy, ob_n_err, ob_first_done); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        a_key_valid = 1'b1;
        a_key_code = 4'd4;
        @(posedge clk);
        #1;
        a_key_code = 4'd6;
        observe(1'b0, 200, 3'd1);
        n_cmp++; if (ob_n011 !== 8 || ob_n110 !== 8 || ob_n_act !== 16) begin n_fail++; $display("FAIL b2b_active got011=%0d got110=%0d all=%0d exp=8/8/16", ob_n011, ob_n110, ob_n_act); end
        n_cmp++; if (ob_first_col !== 3'b011 || ob_wrong_sel !== 0) begin n_fail++; $display("FAIL b2b_order first=%b wrong_sel=%0d exp=011/0", ob_first_col, ob_wrong_sel); end
        n_cmp++; if (ob_n_xfer !== 1 || ob_xfer_idx !== ob_first_done) begin n_fail++; $display("FAIL b2b_accept xfers=%0d at=%0d exp=1 at done=%0d", ob_n_xfer, ob_xfer_idx, ob_first_done); end
        n_cmp++; if (ob_n_done !== 2 || ob_ready_busy !== 0) begin n_fail++; $display("FAIL b2b_done dones=%0d ready_busy=%0d exp=2/0", ob_n_done, ob_ready_busy); end
    endtask

    task automatic test_rows();
        offer(1'b0, 4'd0);
        observe(1'b0, 100, 3'd3);
        n_cmp++; if (ob_n101 !== 8 || ob_n_act !== 8 || ob_wrong_sel !== 0) begin n_fail++; $display("FAIL key0_col got101=%0d all=%0d wrong_sel=%0d exp=8/8/0", ob_n101, ob_n_act, ob_wrong_sel); end
        n_cmp++; if (ob_first_done - ob_last_act !== 28) begin n_fail++; $display("FAIL key0_done offset got=%0d exp=28", ob_first_done - ob_last_act); end
        offer(1'b0, 4'd9);
        observe(1'b0, 100, 3'd2);
        n_cmp++; if (ob_n110 !== 8 || ob_n_act !== 8 || ob_wrong_sel !== 0) begin n_fail++; $display("FAIL key9_col got110=%0d all=%0d wrong_sel=%0d exp=8/8/0", ob_n110, ob_n_act, ob_wrong_sel); end
        n_cmp++; if (ob_first_done - ob_last_act !== 29) begin n_fail++; $display("FAIL key9_done offset got=%0d exp=29", ob_first_done - ob_last_act); end
    endtask

    task automatic test_illegal();
        offer(1'b0, 4'd12);
        observe(1'b0, 30, 3'd0);
        n_cmp++; if (ob_n_err !== 1 || ob_first_err !== 0) begin n_fail++; $display("FAIL illegal_err count=%0d at=%0d exp=1 at 0", ob_n_err, ob_first_err); end
        n_cmp++; if (ob_n_act !== 0 || ob_n_done !== 0) begin n_fail++; $display("FAIL illegal_quiet act=%0d done=%0d exp=0/0", ob_n_act, ob_n_done); end
        n_cmp++; if (ob_n_notready !== 0 || ob_n_busy !== 0) begin n_fail++; $display("FAIL illegal_ready notready=%0d busy=%0d exp=0/0", ob_n_notready, ob_n_busy); end
    endtask

    task automatic test_short_scans();
        int waited;
        waited = 0;
        @(negedge clk);
        while (sel !== 3'd5 && waited < 12) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++; if (sel !== 3'd5) begin n_fail++; $display("FAIL short_sync sel=%0d exp=5", sel); end
        b_key_valid = 1'b1;
        b_key_code = 4'd8;
        @(posedge clk);
        #1;
        b_key_valid = 1'b0;
        observe(1'b1, 30, 3'd2);
        n_cmp++; if (ob_n101 !== 1 || ob_n_act !== 1 || ob_first_act !== 2) begin n_fail++; $display("FAIL short_press got101=%0d all=%0d at=%0d exp=1/1/2", ob_n101, ob_n_act, ob_first_act); end
        n_cmp++; if (ob_n_busy !== 13 || ob_first_done !== 13 || ob_n_done !== 1) begin n_fail++; $display("FAIL short_timing busy=%0d done_at=%0d dones=%0d exp=13/13/1", ob_n_busy, ob_first_done, ob_n_done); end
    endtask

    task automatic test_reset_mid_press();
        int waited;
        waited = 0;
        offer(1'b0, 4'd1);
        @(negedge clk);
        while (a_column === 3'b111 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++; if (a_column !== 3'b011) begin n_fail++; $display("FAIL midrst_press got=%b exp=011", a_column); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (a_column !== 3'b111 || a_key_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_async column=%b ready=%b exp=111/1", a_column, a_key_ready); end
        n_cmp++; if ({a_busy, a_done, a_err} !== 3'b000) begin n_fail++; $display("FAIL midrst_flags got=%b exp=000", {a_busy, a_done, a_err}); end
        @(negedge clk);
        rst_n = 1'b1;
        observe(1'b0, 40, 3'd0);
        n_cmp++; if (ob_n_act !== 0 || ob_n_done !== 0 || ob_n_busy !== 0) begin n_fail++; $display("FAIL midrst_discard act=%0d done=%0d busy=%0d exp=0/0/0", ob_n_act, ob_n_done, ob_n_busy); end
    endtask

    initial begin
        test_reset();
        test_key2();
        test_back_to_back();
        test_rows();
        test_illegal();
        test_short_scans();
        test_reset_mid_press();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
